// File: rtl/mem_dump_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_dump_unit_pkg
// | Shared constants, state encoding and sizing helpers for the memory dump unit.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package mem_dump_unit_pkg;

  localparam int c_MEM_ADDR_SIZE   = 5;
  localparam int c_DATA_SIZE       = 32;
  localparam int c_BYTE_SIZE       = 8;
  localparam int c_BYTES_PER_WORD  = c_DATA_SIZE / c_BYTE_SIZE;
  localparam int c_LAST_ADDR       = (1 << c_MEM_ADDR_SIZE) - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int bytes_per_word(input int data_size, input int byte_size);
    return data_size / byte_size;
  endfunction

  function automatic int last_addr(input int addr_size);
    return (1 << addr_size) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dump_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_dump_unit_if
// | Memory-port and UART-handshake bundle between the dump unit and its peers.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface mem_dump_unit_if
  import mem_dump_unit_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = c_MEM_ADDR_SIZE,
  parameter int DATA_SIZE     = c_DATA_SIZE,
  parameter int BYTE_SIZE     = c_BYTE_SIZE
);

  logic                     i_start;
  logic                     i_tx_done;
  logic [DATA_SIZE-1:0]     i_mem_data;
  logic                     o_debug_unit_flag;
  logic                     o_memory_data_read_enable;
  logic [MEM_ADDR_SIZE-1:0] o_memory_data_read_addr;
  logic                     o_tx_start;
  logic [BYTE_SIZE-1:0]     o_tx_data;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    input  i_start, i_tx_done, i_mem_data,
    output o_debug_unit_flag, o_memory_data_read_enable, o_memory_data_read_addr,
    output o_tx_start, o_tx_data, o_busy, o_done
  );

  modport slave (
    output i_start, i_tx_done, i_mem_data,
    input  o_debug_unit_flag, o_memory_data_read_enable, o_memory_data_read_addr,
    input  o_tx_start, o_tx_data, o_busy, o_done
  );

endinterface
`default_nettype wire

// File: rtl/mem_dump_unit_word_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_dump_unit_word_serializer
// | Holds one memory word and presents it a byte at a time, MSB byte first.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mem_dump_unit_word_serializer
  import mem_dump_unit_pkg::*;
#(
  parameter int DATA_SIZE = c_DATA_SIZE,
  parameter int BYTE_SIZE = c_BYTE_SIZE
) (
  input  wire                  i_clk,
  input  wire                  i_reset,
  input  wire                  i_load,
  input  wire                  i_advance,
  input  wire [DATA_SIZE-1:0]  i_word,
  output logic [BYTE_SIZE-1:0] o_byte,
  output logic                 o_last_byte
);

  localparam int c_BPW   = bytes_per_word(DATA_SIZE, BYTE_SIZE);
  localparam int c_IDX_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BPW - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  logic [DATA_SIZE-1:0] r_word;
  logic [c_IDX_W-1:0]   r_idx;
  logic [DATA_SIZE-1:0] w_shifted;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= '0;
    end else if (i_advance && (r_idx != c_LAST_IDX)) begin
      r_idx  <= r_idx + c_IDX_ONE;
    end
  end

  // Shift the selected byte up to the top so the output slice is constant.
  assign w_shifted   = r_word << (BYTE_SIZE * int'(r_idx));
  assign o_byte      = w_shifted[DATA_SIZE-1 -: BYTE_SIZE];
  assign o_last_byte = (r_idx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/mem_dump_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mem_dump_unit
// | Walks the whole data memory and streams every word to the debug UART.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = c_MEM_ADDR_SIZE,
  parameter int DATA_SIZE     = c_DATA_SIZE,
  parameter int BYTE_SIZE     = c_BYTE_SIZE
) (
  input wire               i_clk,
  input wire               i_reset,
  mem_dump_unit_if.master  bus
);

  localparam logic [MEM_ADDR_SIZE-1:0] c_ADDR_LAST = MEM_ADDR_SIZE'(last_addr(MEM_ADDR_SIZE));
  localparam logic [MEM_ADDR_SIZE-1:0] c_ADDR_ONE  = MEM_ADDR_SIZE'(1);

  state_t                   r_state;
  logic [MEM_ADDR_SIZE-1:0] r_addr;
  logic [MEM_ADDR_SIZE-1:0] r_rd_addr;
  logic                     r_owned;
  logic                     r_rd_en;
  logic                     r_tx_start;
  logic                     r_done;

  logic                     w_load;
  logic                     w_advance;
  logic                     w_last_byte;
  logic [BYTE_SIZE-1:0]     w_tx_byte;

  assign w_load    = (r_state == ST_LATCH);
  assign w_advance = (r_state == ST_WAIT_TX) && bus.i_tx_done && !w_last_byte;

  mem_dump_unit_word_serializer #(
    .DATA_SIZE (DATA_SIZE),
    .BYTE_SIZE (BYTE_SIZE)
  ) u_serializer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_advance   (w_advance),
    .i_word      (bus.i_mem_data),
    .o_byte      (w_tx_byte),
    .o_last_byte (w_last_byte)
  );

  // Outputs are registered alongside the state so they reflect the state being entered.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rd_addr  <= '0;
      r_owned    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_en    <= 1'b0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state   <= ST_READ;
            r_owned   <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_addr;
          end
        end
        ST_READ: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_state    <= ST_SEND;
          r_tx_start <= 1'b1;
        end
        ST_SEND: r_state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (bus.i_tx_done) begin
            if (!w_last_byte) begin
              r_state    <= ST_SEND;
              r_tx_start <= 1'b1;
            end else if (r_addr == c_ADDR_LAST) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_READ;
              r_addr    <= r_addr + c_ADDR_ONE;
              r_rd_addr <= r_addr + c_ADDR_ONE;
              r_rd_en   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_addr    <= r_addr + c_ADDR_ONE;
          r_rd_addr <= '0;
          r_owned   <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_addr    <= '0;
          r_rd_addr <= '0;
          r_owned   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_debug_unit_flag         = r_owned;
  assign bus.o_busy                    = r_owned;
  assign bus.o_memory_data_read_enable = r_rd_en;
  assign bus.o_memory_data_read_addr   = r_rd_addr;
  assign bus.o_tx_start                = r_tx_start;
  assign bus.o_tx_data                 = w_tx_byte;
  assign bus.o_done                    = r_done;

endmodule
`default_nettype wire

// File: doc/mem_dump_unit.md
Name: mem_dump_unit

Overview:
- Debug-side sequencer that dumps the full data memory of the MEM stage over the debug UART.
- Sits directly upstream of the MEM-stage debug/pipeline select mux.
- Drives the debug flag, read-enable and read address into that mux, captures the returned word, and streams it MSB-byte first to the UART transmitter with a start/done handshake.

Parameters:
- MEM_ADDR_SIZE, 5: data-memory address width; dump covers 2**MEM_ADDR_SIZE words.
- DATA_SIZE, 32: memory word width; must be a multiple of BYTE_SIZE.
- BYTE_SIZE, 8: UART payload width.

Ports:
- i_clk  input  1  single clock; all state on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- i_tx_done  input  1  UART transmitter byte-complete pulse.
- i_mem_data  input  DATA_SIZE  data-memory read data, valid 1 cycle after read-enable.
- o_debug_unit_flag  output  1  high while the dump owns the memory port.
- o_memory_data_read_enable  output  1  memory read strobe.
- o_memory_data_read_addr  output  MEM_ADDR_SIZE  memory read address.
- o_tx_start  output  1  one-cycle strobe to UART transmitter.
- o_tx_data  output  BYTE_SIZE  byte to transmit, held stable from o_tx_start until i_tx_done.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse when the last byte of the last word completes.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; address counter 0; byte index 0; word register 0. All outputs 0, including o_tx_data and o_memory_data_read_addr.
- States: IDLE, READ, LATCH, SEND, WAIT_TX, DONE.
- IDLE: i_start=1 moves to READ. Address counter is 0 on entry.
- READ (1 cycle):
  - o_memory_data_read_enable=1 and o_memory_data_read_addr=counter.
  - Next state LATCH.
- LATCH (1 cycle):
  - Captures i_mem_data into the word register; byte index cleared to 0.
  - Next state SEND.
- SEND (1 cycle):
  - o_tx_start=1.
  - o_tx_data = word[DATA_SIZE-1-8*idx -: BYTE_SIZE], i.e. MSB byte first.
  - Next state WAIT_TX.
- WAIT_TX (holds o_tx_data):
  - i_tx_done with idx < DATA_SIZE/BYTE_SIZE-1: increment idx, go to SEND.
  - i_tx_done on the last byte, counter not at the last address: increment counter, go to READ.
  - i_tx_done on the last byte, counter at 2**MEM_ADDR_SIZE-1: go to DONE.
- DONE (1 cycle):
  - o_done=1; counter wraps to 0.
  - Next state IDLE.
- o_debug_unit_flag: registered-state decode; 1 in READ, LATCH, SEND, WAIT_TX and DONE; 0 in IDLE.
- o_memory_data_read_addr: holds the counter value in every state except IDLE, where it is 0. o_memory_data_read_enable is 1 only in READ.
- Latency:
  - i_start at edge N gives READ in cycle N+1 and the first o_tx_start in cycle N+3.
  - Each subsequent byte starts one cycle after its preceding i_tx_done.
- Boundary conditions:
  - i_start while busy: ignored, no restart.
  - i_tx_done outside WAIT_TX, including the SEND cycle itself: ignored.
  - i_tx_done held high: advances at most one byte per SEND/WAIT_TX pair and never skips a byte.
  - i_reset low mid-dump: immediate return to IDLE with all outputs 0. A partial byte already handed to the UART is not the block's concern.
  - Counter arithmetic is MEM_ADDR_SIZE wide; the last address is detected by compare, not by overflow.

Decomposition:
- Shared debug package holds:
  - the state encoding constants (3-bit);
  - BYTES_PER_WORD = DATA_SIZE/BYTE_SIZE;
  - the last-address constant.
- One natural sub-module, word_serializer:
  - holds the word register and byte index;
  - outputs the selected byte and a last_byte flag.
- The FSM and address counter stay in the top.

Test Plan:
- Reset check: assert i_reset=0 mid-simulation -> all outputs 0 and o_busy=0 in the same cycle (asynchronous).
- Single-word byte order:
  - Stimulus: memory model word0=0xDEADBEEF, i_start, i_tx_done returned 10 cycles after each o_tx_start.
  - Response: o_tx_data sequence begins 0xDE,0xAD,0xBE,0xEF; first o_tx_start exactly 3 cycles after i_start.
- Full dump:
  - Stimulus: memory word k = k*0x01010101, k=0..31.
  - Response: exactly 128 o_tx_start pulses; read addresses 0..31 in order; one o_done pulse after the 128th i_tx_done; o_debug_unit_flag=0 afterwards.
- Start while busy: i_start pulsed during word 3 -> no change in address sequence; total still 128 bytes and one o_done.
- Spurious/held tx_done:
  - Stimulus: i_tx_done in the SEND cycle, then i_tx_done held high continuously.
  - Response: no byte skipped; byte sequence identical to the full-dump case.
- Reset mid-dump: i_reset low during word 10 byte 2, then i_start -> dump restarts at address 0 with byte 0xDE-style MSB first; 128 bytes total after restart.
